// File: rtl/register.sv
// rtl/register.sv - N-bit load-enable register, per-bit async clear; REGISTER_PARITY_EN adds a registered even-parity output
module register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic             reset,
    input  logic             clk,
    output logic [WIDTH-1:0] out
`ifdef REGISTER_PARITY_EN
    ,
    output logic             parity
`endif
);

    // One flop per bit; the hold path recirculates the stored bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bit_q;
        logic bit_d;

        assign bit_d = enable ? data[i] : bit_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                bit_q <= RESET_VALUE[i];
            end else begin
                bit_q <= bit_d;
            end
        end

        assign out[i] = bit_q;
    end

`ifdef REGISTER_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Parity of the incoming word, so it lands on the same edge as out.
    assign parity_d = enable ? (^data) : parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= ^RESET_VALUE;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_register.sv
// tb/tb_register.sv - scoreboard bench for register: 32-bit zero-reset and 8-bit 0xA5-reset instances
module tb_register;

    localparam logic [31:0] RV32 = 32'h0;
    localparam logic [7:0]  RV8  = 8'hA5;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] data;
    logic [31:0] out32;
    logic [7:0]  out8;
`ifdef REGISTER_PARITY_EN
    logic        par32;
    logic        par8;
`endif

    register #(.WIDTH(32), .RESET_VALUE(RV32)) dut32 (
        .data   (data),
        .enable (enable),
        .reset  (reset),
        .clk    (clk),
        .out    (out32)
`ifdef REGISTER_PARITY_EN
        ,
        .parity (par32)
`endif
    );

    register #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
        .data   (data[7:0]),
        .enable (enable),
        .reset  (reset),
        .clk    (clk),
        .out    (out8)
`ifdef REGISTER_PARITY_EN
        ,
        .parity (par8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] v32;
        logic [7:0]  v8;
        logic        p32;
        logic        p8;
    } exp_t;

    exp_t        sb[$];
    event        chk_ev;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m32;
    logic [7:0]  m8;

    // Reference: reset wins, else enable loads the word, else hold.
    task automatic apply_edge();
        if (reset) begin
            m32 = RV32;
            m8  = RV8;
        end else if (enable) begin
            m32 = data;
            m8  = data[7:0];
        end
    endtask

    task automatic expect_now(input string n);
        exp_t e;
        e.name = n;
        e.v32  = m32;
        e.v8   = m8;
        e.p32  = 1'($countones(m32) % 2);
        e.p8   = 1'($countones(m8) % 2);
        sb.push_back(e);
        ->chk_ev;
        #2;
    endtask

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL monitor_underflow: got empty queue expected entry");
            end else begin
                e = sb.pop_front();
                cmp({e.name, "_out32"}, out32, e.v32);
                cmp({e.name, "_out8"}, {24'h0, out8}, {24'h0, e.v8});
`ifdef REGISTER_PARITY_EN
                cmp({e.name, "_par32"}, {31'h0, par32}, {31'h0, e.p32});
                cmp({e.name, "_par8"}, {31'h0, par8}, {31'h0, e.p8});
`endif
            end
        end
    end

    task automatic cycle(input logic [31:0] d, input logic en, input logic r, input string n);
        @(negedge clk);
        data   = d;
        enable = en;
        reset  = r;
        @(posedge clk);
        apply_edge();
        expect_now(n);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        data   = 32'h0;
        m32    = 32'h0;
        m8     = 8'h0;
        #1 reset = 1'b1;
        m32 = RV32;
        m8  = RV8;
        #1 expect_now("reset_init");

        cycle(32'd45, 1'b1, 1'b0, "load45");
        cycle(32'd67, 1'b0, 1'b0, "hold");

        // Async assertion mid-cycle, then hold through edges while asserted.
        @(negedge clk);
        enable = 1'b1;
        data   = 32'd98;
        #2 reset = 1'b1;
        m32 = RV32;
        m8  = RV8;
        expect_now("async_reset");
        repeat (2) begin
            @(posedge clk);
            apply_edge();
            expect_now("reset_hold");
        end

        @(negedge clk);
        data   = 32'hDEADBEEF;
        enable = 1'b1;
        #1 reset = 1'b0;
        expect_now("release_no_change");
        @(posedge clk);
        apply_edge();
        expect_now("release_load");

        @(negedge clk);
        enable = 1'b1;
        data = 32'h1;
        #1 data = 32'h2;
        #1 data = 32'h3;
        #1 data = 32'h4;
        @(posedge clk);
        apply_edge();
        expect_now("glitch");

        data = 32'h12345678;
        @(negedge clk);
        expect_now("falling_edge");
        enable = 1'b0;

        cycle(32'h7, 1'b1, 1'b0, "load7");
        cycle(32'h3, 1'b1, 1'b0, "load3");
        cycle(32'hFFFF_FFFF, 1'b1, 1'b0, "load_ones");
        cycle(32'h0, 1'b0, 1'b1, "sync_reset");

        for (int k = 0; k < 300; k++) begin
            cycle($urandom, 1'($urandom % 2), ($urandom % 20) == 0, "rand");
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
